// File: rtl/switch_port_ingress.sv
// Per-port ingress buffer: accepts packets on a valid/ready handshake, drops malformed
// or loopback packets, and presents the FIFO head to the crossbar arbiter as a request/grant pair.
module switch_port_ingress #(
    parameter int          DEPTH   = 4,
    parameter logic [3:0]  PORT_ID = 4'b0001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic [3:0] source_in,
    input  logic [3:0] target_in,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic [3:0] fwd_req,
    output logic [3:0] fwd_source,
    output logic [3:0] fwd_target,
    output logic [7:0] fwd_data,
    input  logic       fwd_gnt,
    output logic [7:0] drop_cnt,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [3:0]    src_mem  [DEPTH];
    logic [3:0]    tgt_mem  [DEPTH];
    logic [7:0]    data_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic tgt_onehot;
    logic pkt_bad;
    logic accept;
    logic push;
    logic drop;
    logic pop;

    always_comb begin
        full       = (count == DEPTH_C);
        empty      = (count == '0);
        // Held low during reset so the initiator never sees a transfer against cleared state.
        ready      = rst_n & ~full;

        tgt_onehot = (target_in != 4'd0) && ((target_in & (target_in - 4'd1)) == 4'd0);
        pkt_bad    = !tgt_onehot || (target_in == PORT_ID) || (source_in != PORT_ID);

        accept     = valid_in & ready;
        push       = accept & ~pkt_bad;
        drop       = accept & pkt_bad;
        pop        = fwd_gnt & ~empty;
    end

    always_comb begin
        fwd_source = '0;
        fwd_target = '0;
        fwd_data   = '0;
        if (!empty) begin
            fwd_source = src_mem[rd_ptr];
            fwd_target = tgt_mem[rd_ptr];
            fwd_data   = data_mem[rd_ptr];
        end
        fwd_req = fwd_target;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // NOTE: payload storage is not reset; outputs are masked by empty, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_ptr]  <= source_in;
            tgt_mem[wr_ptr]  <= target_in;
            data_mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_switch_port_ingress.sv
// Self-checking bench for switch_port_ingress: queue-based reference model compared every
// negative clock edge, plus directed scenarios with literal expectations.
module tb_switch_port_ingress;

    localparam int         DEPTH   = 4;
    localparam logic [3:0] PORT_ID = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid_in = 1'b0;
    logic [3:0] source_in = '0;
    logic [3:0] target_in = '0;
    logic [7:0] data_in = '0;
    logic       ready;
    logic [3:0] fwd_req;
    logic [3:0] fwd_source;
    logic [3:0] fwd_target;
    logic [7:0] fwd_data;
    logic       fwd_gnt = 1'b0;
    logic [7:0] drop_cnt;
    logic       full;
    logic       empty;

    switch_port_ingress #(.DEPTH(DEPTH), .PORT_ID(PORT_ID)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .source_in  (source_in),
        .target_in  (target_in),
        .data_in    (data_in),
        .ready      (ready),
        .fwd_req    (fwd_req),
        .fwd_source (fwd_source),
        .fwd_target (fwd_target),
        .fwd_data   (fwd_data),
        .fwd_gnt    (fwd_gnt),
        .drop_cnt   (drop_cnt),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of packets and a drop counter.
    typedef struct packed {
        logic [3:0] src;
        logic [3:0] tgt;
        logic [7:0] data;
    } pkt_t;

    pkt_t m_q[$];
    int   m_drops = 0;

    function automatic bit is_bad(input logic [3:0] src, input logic [3:0] tgt);
        return ($countones(tgt) != 1) || (tgt == PORT_ID) || (src != PORT_ID);
    endfunction

    always @(negedge rst_n) begin
        m_q.delete();
        m_drops = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            bit acc;
            bit pop;
            acc = valid_in && (m_q.size() < DEPTH);
            pop = fwd_gnt && (m_q.size() > 0);
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                if (is_bad(source_in, target_in)) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_q.push_back('{src: source_in, tgt: target_in, data: data_in});
                end
            end
        end
    end

    always @(negedge clk) begin
        pkt_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        check("ready",      ready,      rst_n && (m_q.size() < DEPTH));
        check("empty",      empty,      m_q.size() == 0);
        check("full",       full,       m_q.size() == DEPTH);
        check("fwd_req",    fwd_req,    h.tgt);
        check("fwd_source", fwd_source, h.src);
        check("fwd_target", fwd_target, h.tgt);
        check("fwd_data",   fwd_data,   h.data);
        check("drop_cnt",   drop_cnt,   m_drops);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a packet and hold it until a transfer edge, bounded by a cycle budget.
    task automatic send(input logic [3:0] src, input logic [3:0] tgt, input logic [7:0] d);
        bit done;
        done      = 0;
        valid_in  = 1'b1;
        source_in = src;
        target_in = tgt;
        data_in   = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1;
            cyc();
        end
        valid_in = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) cyc();
        check("rst_ready", ready, 1'b0);
        check("rst_empty", empty, 1'b1);
        #2 rst_n = 1'b1;
        cyc();
        check("post_rst_ready", ready, 1'b1);

        // Single packet, visible one edge after transfer, then popped.
        send(4'b0001, 4'b0100, 8'hA5);
        check("single_req", fwd_req, 4'b0100);
        check("single_data", fwd_data, 8'hA5);
        fwd_gnt = 1'b1;
        cyc();
        fwd_gnt = 1'b0;
        check("single_pop_empty", empty, 1'b1);
        check("single_pop_req", fwd_req, 4'b0000);

        // Fill to DEPTH, then a grant frees a slot only after the edge.
        for (int d = 1; d <= 4; d++) send(4'b0001, 4'b0010, 8'(d));
        check("fill_full", full, 1'b1);
        check("fill_ready", ready, 1'b0);
        valid_in = 1'b1; source_in = 4'b0001; target_in = 4'b0010; data_in = 8'd5;
        fwd_gnt = 1'b1;
        check("gnt_cycle_ready", ready, 1'b0);
        check("pop_order_1", fwd_data, 8'd1);
        cyc();
        fwd_gnt = 1'b0;
        check("after_gnt_ready", ready, 1'b1);
        cyc();
        valid_in = 1'b0;
        check("refill_full", full, 1'b1);
        for (int d = 2; d <= 5; d++) begin
            check($sformatf("pop_order_%0d", d), fwd_data, 8'(d));
            fwd_gnt = 1'b1;
            cyc();
            fwd_gnt = 1'b0;
        end
        check("drain_empty", empty, 1'b1);

        // Drop rules.
        send(4'b0001, 4'b0000, 8'h11);
        send(4'b0001, 4'b0110, 8'h12);
        send(4'b0001, 4'b0001, 8'h13);
        send(4'b0010, 4'b0100, 8'h14);
        check("drop_cnt_4", drop_cnt, 8'd4);
        check("drop_empty", empty, 1'b1);
        valid_in = 1'b1; source_in = 4'b0001; target_in = 4'b0000;
        repeat (260) cyc();
        valid_in = 1'b0;
        check("drop_cnt_sat", drop_cnt, 8'd255);

        // Simultaneous push and pop with one entry.
        send(4'b0001, 4'b1000, 8'd7);
        valid_in = 1'b1; source_in = 4'b0001; target_in = 4'b1000; data_in = 8'd8;
        fwd_gnt = 1'b1;
        cyc();
        valid_in = 1'b0; fwd_gnt = 1'b0;
        check("pp_data", fwd_data, 8'd8);
        check("pp_req", fwd_req, 4'b1000);
        check("pp_one_left", {full, empty}, 2'b00);
        fwd_gnt = 1'b1;
        cyc();
        fwd_gnt = 1'b0;

        // Spurious grant, then wrap.
        fwd_gnt = 1'b1;
        repeat (2) cyc();
        fwd_gnt = 1'b0;
        check("spurious_empty", empty, 1'b1);
        for (int i = 0; i < 10; i++) begin
            send(4'b0001, 4'b0100, 8'(8'h20 + i));
            check($sformatf("wrap_data_%0d", i), fwd_data, 8'(8'h20 + i));
            fwd_gnt = 1'b1;
            cyc();
            fwd_gnt = 1'b0;
        end
        check("wrap_empty", empty, 1'b1);

        // Asynchronous reset with packets buffered.
        for (int i = 0; i < 3; i++) send(4'b0001, 4'b0010, 8'(8'h40 + i));
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", fwd_req, 4'b0000);
        check("arst_empty", empty, 1'b1);
        check("arst_ready", ready, 1'b0);
        check("arst_drop", drop_cnt, 8'd0);
        cyc();
        #2 rst_n = 1'b1;
        cyc();
        check("arst_rel_ready", ready, 1'b1);
        check("arst_rel_req", fwd_req, 4'b0000);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] tgts [6];
            tgts = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b1100};
            valid_in  = ($urandom_range(0, 3) != 0);
            source_in = ($urandom_range(0, 7) == 0) ? 4'b0100 : PORT_ID;
            target_in = ($urandom_range(0, 3) == 0) ? tgts[$urandom_range(3, 5)]
                                                     : tgts[$urandom_range(0, 2)];
            data_in   = 8'($urandom);
            fwd_gnt   = ($urandom_range(0, 2) == 0);
            cyc();
        end
        valid_in = 1'b0;
        fwd_gnt  = 1'b0;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
